// File: rtl/sbox_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// sbox_cfg_ctrl
//
// Frame-aligned selection controller for a two-output sbox. A configuration
// request only changes the sbox selection on a frame boundary, after the
// producer channel has been stalled for a guard interval, so no token is
// ever in flight across a selection change. Token data does not pass
// through this block; only the write strobe and full_n flag are gated.
//
// Parameters
//   FRAME_LEN   tokens per frame (1..65535)
//   GUARD_CYC   stall cycles held before the selection flips (1..255)
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   cfg_req      in   single-cycle request for a new selection
//   cfg_sel      in   requested selection (0 -> out1, 1 -> out2)
//   cfg_busy     out  high while a request is in progress
//   cfg_ack      out  one-cycle pulse when a request completes
//   sel          out  registered selection to the sbox sel input
//   prod_write   in   producer write strobe
//   prod_full_n  out  space-available flag to the producer
//   sbox_write   out  gated write strobe to sbox in1_write
//   sbox_full_n  in   space-available flag from sbox in1_full_n
//
// States
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no request outstanding, tokens flow freely
//   WAIT   | request latched, letting the current frame finish
//   HOLD   | at frame boundary, channel stalled for GUARD_CYC cycles
//   SWITCH | channel still stalled, selection updated at end of cycle
// ---------------------------------------------------------------------------
module sbox_cfg_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int GUARD_CYC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic cfg_req,
    input  logic cfg_sel,
    output logic cfg_busy,
    output logic cfg_ack,
    output logic sel,
    input  logic prod_write,
    output logic prod_full_n,
    output logic sbox_write,
    input  logic sbox_full_n
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [7:0]       GUARD_LOAD = 8'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       guard_q, guard_d;
    logic             pend_sel_q, pend_sel_d;
    logic             sel_q, sel_d;
    logic             ack_q, ack_d;

    logic hold;
    logic accept;

    // Channel gating. Hold is forced low while reset is asserted so the
    // producer sees the raw sbox flag even before the state register clears.
    always_comb begin
        hold = !reset &&
               (((state_q == ST_WAIT) && (cnt_q == '0)) ||
                (state_q == ST_HOLD) ||
                (state_q == ST_SWITCH));
        prod_full_n = sbox_full_n && !hold;
        sbox_write  = prod_write && !hold;
        accept      = sbox_write && sbox_full_n;
    end

    // Frame counter: counts accepted tokens only, so backpressure simply
    // freezes it. With a frame of one it stays pinned at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        pend_sel_d = pend_sel_q;
        sel_d      = sel_q;
        ack_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    if (cfg_sel == sel_q) begin
                        // Already selected: acknowledge without stalling.
                        ack_d = 1'b1;
                    end else begin
                        pend_sel_d = cfg_sel;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // cnt==0 here is a frame boundary and hold is already up,
                // so no token can slip in during the transition.
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_HOLD: begin
                if (guard_q == 8'd0) begin
                    state_d = ST_SWITCH;
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end
            ST_SWITCH: begin
                sel_d   = pend_sel_q;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            guard_q    <= 8'd0;
            pend_sel_q <= 1'b0;
            sel_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            pend_sel_q <= pend_sel_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
        end
    end

    assign cfg_busy = (state_q != ST_IDLE);
    assign cfg_ack  = ack_q;
    assign sel      = sel_q;

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sbox_cfg_ctrl
//
// Directed bench for sbox_cfg_ctrl. Instance dut uses FRAME_LEN=4,
// GUARD_CYC=2; instance dut1 uses FRAME_LEN=1, GUARD_CYC=2. Inputs change
// just after the falling edge and outputs are compared 1ns later.
// ---------------------------------------------------------------------------
module tb_sbox_cfg_ctrl;

    logic clock;
    logic reset;

    logic cfg_req, cfg_sel, prod_write, sbox_full_n;
    logic cfg_busy, cfg_ack, sel, prod_full_n, sbox_write;

    logic d1_cfg_req, d1_cfg_sel, d1_prod_write, d1_sbox_full_n;
    logic d1_cfg_busy, d1_cfg_ack, d1_sel, d1_prod_full_n, d1_sbox_write;

    int checks;
    int failures;

    sbox_cfg_ctrl #(.FRAME_LEN(4), .GUARD_CYC(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_req     (cfg_req),
        .cfg_sel     (cfg_sel),
        .cfg_busy    (cfg_busy),
        .cfg_ack     (cfg_ack),
        .sel         (sel),
        .prod_write  (prod_write),
        .prod_full_n (prod_full_n),
        .sbox_write  (sbox_write),
        .sbox_full_n (sbox_full_n)
    );

    sbox_cfg_ctrl #(.FRAME_LEN(1), .GUARD_CYC(2)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .cfg_req     (d1_cfg_req),
        .cfg_sel     (d1_cfg_sel),
        .cfg_busy    (d1_cfg_busy),
        .cfg_ack     (d1_cfg_ack),
        .sel         (d1_sel),
        .prod_write  (d1_prod_write),
        .prod_full_n (d1_prod_full_n),
        .sbox_write  (d1_sbox_write),
        .sbox_full_n (d1_sbox_full_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic pw;
        logic fn;
        logic req;
        logic cs;
        logic e_pfn;
        logic e_sw;
        logic e_sel;
        logic e_ack;
        logic e_busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic chk_main(input string tag, input logic e_pfn, input logic e_sw,
                            input logic e_sel, input logic e_ack, input logic e_busy);
        chk({tag, " prod_full_n"}, prod_full_n, e_pfn);
        chk({tag, " sbox_write"},  sbox_write,  e_sw);
        chk({tag, " sel"},         sel,         e_sel);
        chk({tag, " cfg_ack"},     cfg_ack,     e_ack);
        chk({tag, " cfg_busy"},    cfg_busy,    e_busy);
    endtask

    task automatic chk_d1(input string tag, input logic e_pfn, input logic e_sw,
                          input logic e_sel, input logic e_ack, input logic e_busy);
        chk({tag, " prod_full_n"}, d1_prod_full_n, e_pfn);
        chk({tag, " sbox_write"},  d1_sbox_write,  e_sw);
        chk({tag, " sel"},         d1_sel,         e_sel);
        chk({tag, " cfg_ack"},     d1_cfg_ack,     e_ack);
        chk({tag, " cfg_busy"},    d1_cfg_busy,    e_busy);
    endtask

    task automatic drive(input logic pw, input logic fn, input logic req, input logic cs);
        prod_write  = pw;
        sbox_full_n = fn;
        cfg_req     = req;
        cfg_sel     = cs;
    endtask

    task automatic drive_d1(input logic pw, input logic fn, input logic req, input logic cs);
        d1_prod_write  = pw;
        d1_sbox_full_n = fn;
        d1_cfg_req     = req;
        d1_cfg_sel     = cs;
    endtask

    initial begin
        int acks;
        checks   = 0;
        failures = 0;

        // Mid-frame switch, redundant request, backpressure pass-through.
        //               pw fn req cs   pfn sw sel ack busy
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive_d1(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        next_cycle();
        #1;
        chk("in_reset prod_full_n low", prod_full_n, 1'b0);
        sbox_full_n = 1'b1;
        #1;
        chk("in_reset prod_full_n high", prod_full_n, 1'b1);
        reset = 1'b0;
        #1;
        chk_main("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_d1("d1 reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pw, tbl[i].fn, tbl[i].req, tbl[i].cs);
            #1;
            chk_main($sformatf("vec%0d", i), tbl[i].e_pfn, tbl[i].e_sw,
                     tbl[i].e_sel, tbl[i].e_ack, tbl[i].e_busy);
            next_cycle();
        end

        // Backpressure in WAIT with cnt=3, sel=1 -> request sel 0.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk_main("bp req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk_main($sformatf("bp stall%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_main("bp last token", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            chk_main($sformatf("bp hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            next_cycle();
        end
        #1;
        chk_main("bp switched", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        #1;
        chk("bp ack drop", cfg_ack, 1'b0);

        // Ignored requests while busy, then a request in the ack cycle.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk_main("ign req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            logic e_sel, e_ack, e_busy;
            case (i)
                1:       drive(1'b0, 1'b1, 1'b1, 1'b1);
                2, 3, 4: drive(1'b0, 1'b1, 1'b1, 1'b0);
                6:       drive(1'b0, 1'b1, 1'b1, 1'b1);
                default: drive(1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            e_sel  = (i >= 4 && i < 9);
            e_ack  = (i == 4 || i == 9);
            e_busy = !e_ack;
            #1;
            if (i < 5 && cfg_ack) acks++;
            chk_main($sformatf("ign cyc%0d", i), !e_busy, 1'b0, e_sel, e_ack, e_busy);
            next_cycle();
        end
        chk("ign single ack", (acks == 1), 1'b1);

        // Reset mid-WAIT with cnt=2, then reset in HOLD.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("rst tok%0d sbox_write", i), sbox_write, 1'b1);
            next_cycle();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst wait busy", cfg_busy, 1'b1);
        chk("rst wait prod_full_n", prod_full_n, 1'b1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk_main("rst after wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk_main("rst cnt cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        #1;
        chk_main("rst in hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst hold prod_full_n", prod_full_n, 1'b1);
        next_cycle();
        reset = 1'b0;
        sbox_full_n = 1'b0;
        #1;
        chk("rst post prod_full_n low", prod_full_n, 1'b0);
        sbox_full_n = 1'b1;
        #1;
        chk_main("rst post hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_main($sformatf("rst quiet%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        // Frame of one.
        drive_d1(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_d1("d1 token", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive_d1(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk_d1("d1 req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive_d1(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic e_busy;
            e_busy = (i < 4);
            #1;
            chk_d1($sformatf("d1 cyc%0d", i), !e_busy, 1'b0, (i >= 4),
                   (i == 4), e_busy);
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive_d1(1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            chk_d1($sformatf("d1 flow%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive_d1(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk_d1("d1 req2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        #1;
        chk_d1("d1 hold2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_d1(1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
